// File: rtl/counter_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_display_scan                                                       |
// | Extends a 4-bit counter with three carry-counted hex digits and scans all  |
// | four digits onto a common-anode 7-segment display.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module counter_display_scan #(
  parameter int SCAN_DIV = 4,
  parameter int BLANK_LZ = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  counter_in,
  input  logic        carry_in,
  input  logic        clear,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [11:0] hi_count,
  output logic        overflow
);

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  logic             carry_prev;
  logic             carry_evt;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit_sel;
  logic [3:0]       digit_val;
  logic             digit_blank;
  logic [6:0]       seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Tracks carry_in through reset so a level held across release is not an event.
  always_ff @(posedge clk) begin
    carry_prev <= carry_in;
  end

  // Event is registered (count lands one edge after the rising edge is seen);
  // clear suppresses it at both stages so it can never leak past a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_evt <= 1'b0;
    end else begin
      carry_evt <= carry_in & ~carry_prev & ~clear;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hi_count <= 12'h000;
      overflow <= 1'b0;
    end else if (carry_evt) begin
      hi_count <= hi_count + 12'd1;
      if (hi_count == 12'hFFF) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    digit_val   = counter_in;
    digit_blank = 1'b0;
    case (digit_sel)
      2'd1: begin
        digit_val   = hi_count[3:0];
        digit_blank = (BLANK_LZ != 0) && (hi_count == 12'h000);
      end
      2'd2: begin
        digit_val   = hi_count[7:4];
        digit_blank = (BLANK_LZ != 0) && (hi_count[11:4] == 8'h00);
      end
      2'd3: begin
        digit_val   = hi_count[11:8];
        digit_blank = (BLANK_LZ != 0) && (hi_count[11:8] == 4'h0);
      end
      default: begin
        digit_val   = counter_in;
        digit_blank = 1'b0;
      end
    endcase
    seg_next = digit_blank ? SEG_BLANK : hex_to_seg(digit_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << digit_sel);
      seg <= seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_counter_display_scan                                                    |
// | Directed bench for counter_display_scan (default, blanking, SCAN_DIV=1).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_counter_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  counter_in;
  logic        carry_in;
  logic        clear;

  logic [3:0]  an,  an_b,  an_1;
  logic [6:0]  seg, seg_b, seg_1;
  logic [11:0] hi_count, hi_count_b, hi_count_1;
  logic        overflow, overflow_b, overflow_1;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  counter_display_scan dut (
    .clk(clk), .reset(reset), .counter_in(counter_in), .carry_in(carry_in),
    .clear(clear), .an(an), .seg(seg), .hi_count(hi_count), .overflow(overflow)
  );

  counter_display_scan #(.BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .counter_in(counter_in), .carry_in(carry_in),
    .clear(clear), .an(an_b), .seg(seg_b), .hi_count(hi_count_b), .overflow(overflow_b)
  );

  counter_display_scan #(.SCAN_DIV(1)) dut_1 (
    .clk(clk), .reset(reset), .counter_in(counter_in), .carry_in(carry_in),
    .clear(clear), .an(an_1), .seg(seg_1), .hi_count(hi_count_1), .overflow(overflow_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  one;
    logic [11:0] prev;
    one        = 4'b0001;
    reset      = 1'b1;
    carry_in   = 1'b1;
    clear      = 1'b0;
    counter_in = 4'hD;

    // Reset with carry held high
    repeat (3) tick();
    chk("rst_an",  {12'd0, an},       16'h000F);
    chk("rst_seg", {9'd0, seg},       16'h007F);
    chk("rst_hi",  {4'd0, hi_count},  16'h0000);
    chk("rst_ovf", {15'd0, overflow}, 16'h0000);

    // Release with carry still high; check the scan over a full frame
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("scan_an",   {12'd0, an},   {12'd0, ~(one << (i / 4))});
      chk("scan_seg",  {9'd0, seg},   (i < 4) ? 16'h0021 : 16'h0040);
      chk("scan_segb", {9'd0, seg_b}, (i < 4) ? 16'h0021 : 16'h007F);
      chk("scan1_an",  {12'd0, an_1}, {12'd0, ~(one << (i % 4))});
    end
    tick();
    chk("scan_wrap_an", {12'd0, an}, 16'h000E);
    chk("held_carry_hi",  {4'd0, hi_count},  16'h0000);
    chk("held_carry_ovf", {15'd0, overflow}, 16'h0000);

    // Three pulses, each high for three cycles; first checks the one-edge latency
    for (int p = 1; p <= 3; p++) begin
      carry_in = 1'b0; tick();
      carry_in = 1'b1; tick();
      chk("carry_latency", {4'd0, hi_count}, 16'(p - 1));
      tick();
      chk("carry_count", {4'd0, hi_count}, 16'(p));
      tick();
    end
    chk("three_pulses", {4'd0, hi_count}, 16'h0003);

    // One long high counts once
    carry_in = 1'b0; tick();
    carry_in = 1'b1;
    repeat (10) tick();
    chk("long_high", {4'd0, hi_count}, 16'h0004);

    clear = 1'b1; tick();
    clear = 1'b0;
    chk("clear_hi", {4'd0, hi_count}, 16'h0000);

    // Preload to FFF, then wrap
    for (int k = 0; k < 4095; k++) begin
      carry_in = 1'b0; tick();
      carry_in = 1'b1; tick();
    end
    carry_in = 1'b0; tick();
    chk("preload_hi",  {4'd0, hi_count},  16'h0FFF);
    chk("preload_ovf", {15'd0, overflow}, 16'h0000);
    carry_in = 1'b1; tick();
    carry_in = 1'b0; tick();
    chk("wrap_hi",  {4'd0, hi_count},  16'h0000);
    chk("wrap_ovf", {15'd0, overflow}, 16'h0001);
    tick();
    chk("ovf_sticky", {15'd0, overflow}, 16'h0001);
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("clear_ovf", {15'd0, overflow}, 16'h0000);

    // Count to 7, then clear coincident with a carry edge
    for (int k = 0; k < 7; k++) begin
      carry_in = 1'b1; tick();
      carry_in = 1'b0; tick();
    end
    chk("count7", {4'd0, hi_count}, 16'h0007);
    carry_in = 1'b1; clear = 1'b1; tick();
    clear = 1'b0;
    chk("clear_evt_hi", {4'd0, hi_count}, 16'h0000);
    tick();
    chk("clear_evt_noinc", {4'd0, hi_count}, 16'h0000);

    // Leading-zero blanking with hi_count = 5, counter_in = 0
    carry_in = 1'b0; counter_in = 4'h0; tick();
    for (int k = 0; k < 5; k++) begin
      carry_in = 1'b1; tick();
      carry_in = 1'b0; tick();
    end
    chk("count5", {4'd0, hi_count_b}, 16'h0005);
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      case (an)
        4'b1110: begin
          chk("blank_d0", {9'd0, seg_b}, 16'h0040);
          chk("plain_d0", {9'd0, seg},   16'h0040);
        end
        4'b1101: begin
          chk("blank_d1", {9'd0, seg_b}, 16'h0012);
          chk("plain_d1", {9'd0, seg},   16'h0012);
        end
        4'b1011: begin
          chk("blank_d2", {9'd0, seg_b}, 16'h007F);
          chk("plain_d2", {9'd0, seg},   16'h0040);
        end
        4'b0111: begin
          chk("blank_d3", {9'd0, seg_b}, 16'h007F);
          chk("plain_d3", {9'd0, seg},   16'h0040);
        end
        default: chk("an_onehot", {12'd0, an}, 16'h000E);
      endcase
    end

    // Reset mid-frame
    reset = 1'b1; tick();
    chk("midrst_an",  {12'd0, an},      16'h000F);
    chk("midrst_seg", {9'd0, seg},      16'h007F);
    chk("midrst_hi",  {4'd0, hi_count}, 16'h0000);
    reset = 1'b0; tick();
    chk("post_rst_an",  {12'd0, an},   16'h000E);
    chk("post_rst_seg", {9'd0, seg},   16'h0040);
    chk("post_rst_an1", {12'd0, an_1}, 16'h000E);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
